// File: rtl/rptr_empty_w2r.sv
`default_nettype none
// ============================================================================
//  Module   : rptr_empty_w2r
//  Purpose  : Read-side pointer and status logic of an asynchronous FIFO.
//             Brings the Gray-coded write pointer into the read clock domain
//             through a two-flop synchronizer. Keeps the binary and Gray read
//             pointers. Produces registered empty, almost-empty and occupancy
//             status, plus a sticky underflow flag.
//
//  Ports    : rclk      - read clock; the only clock
//             rrst      - asynchronous active-high reset
//             rinc      - read request, sampled on the rising edge of rclk
//             wptr      - Gray write pointer from the write clock domain
//             raddr     - binary read address to the FIFO memory
//             rptr      - registered Gray read pointer, sent to the write domain
//             rq2_wptr  - write pointer after synchronization into rclk
//             rempty    - registered FIFO-empty flag
//             raempty   - registered almost-empty flag (count <= threshold)
//             rcount    - registered occupancy as seen from the read side
//             rerr      - sticky underflow flag (read attempted while empty)
//
//  Revision : 1.0 - initial release
// ============================================================================
module rptr_empty_w2r #(
    parameter int ADDRSIZE      = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE:0]   rq2_wptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rcount,
    output logic                rerr
);

    localparam logic [ADDRSIZE:0] c_aempty_thresh = (ADDRSIZE+1)'(AEMPTY_THRESH);

    logic [ADDRSIZE:0] r_rq1_wptr;
    logic [ADDRSIZE:0] r_rbin;

    logic              w_rd_en;
    logic [ADDRSIZE:0] w_rbinnext;
    logic [ADDRSIZE:0] w_rgraynext;
    logic [ADDRSIZE:0] w_rq2_wbin;
    logic [ADDRSIZE:0] w_rcount_next;

    // A read request is honoured only while the FIFO is not empty.
    assign w_rd_en     = rinc & ~rempty;
    assign w_rbinnext  = r_rbin + {{ADDRSIZE{1'b0}}, w_rd_en};
    assign w_rgraynext = (w_rbinnext >> 1) ^ w_rbinnext;

    // The address comes straight from the register, so it is valid in the
    // same cycle that rinc is presented.
    assign raddr = r_rbin[ADDRSIZE-1:0];

    // Gray to binary: each binary bit is the XOR of all Gray bits from the
    // MSB down to that position.
    for (genvar i = 0; i <= ADDRSIZE; i++) begin : g_gray2bin
        assign w_rq2_wbin[i] = ^rq2_wptr[ADDRSIZE:i];
    end

    // Occupancy is taken against the post-read pointer and the currently
    // synchronized write pointer. A write that is still in flight through
    // the synchronizer is not counted yet, so the status never overstates
    // how much data is available. Modulo arithmetic handles the wrap.
    assign w_rcount_next = w_rq2_wbin - w_rbinnext;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_rq1_wptr <= '0;
            rq2_wptr   <= '0;
            r_rbin     <= '0;
            rptr       <= '0;
            rempty     <= 1'b1;
            raempty    <= 1'b1;
            rcount     <= '0;
            rerr       <= 1'b0;
        end else begin
            // Plain two-flop synchronizer, no logic between the stages.
            r_rq1_wptr <= wptr;
            rq2_wptr   <= r_rq1_wptr;

            r_rbin     <= w_rbinnext;
            rptr       <= w_rgraynext;

            rempty     <= (w_rgraynext == rq2_wptr);
            rcount     <= w_rcount_next;
            raempty    <= (w_rcount_next <= c_aempty_thresh);

            if (rinc && rempty) begin
                rerr <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rptr_empty_w2r.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rptr_empty_w2r
//  Purpose  : Directed self-checking bench for rptr_empty_w2r with
//             ADDRSIZE=4 and AEMPTY_THRESH=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rptr_empty_w2r;

    logic       rclk;
    logic       rrst;
    logic       rinc;
    logic [4:0] wptr;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic [4:0] rq2_wptr;
    logic       rempty;
    logic       raempty;
    logic [4:0] rcount;
    logic       rerr;

    int passed;
    int total;

    rptr_empty_w2r #(
        .ADDRSIZE      (4),
        .AEMPTY_THRESH (2)
    ) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .rinc     (rinc),
        .wptr     (wptr),
        .raddr    (raddr),
        .rptr     (rptr),
        .rq2_wptr (rq2_wptr),
        .rempty   (rempty),
        .raempty  (raempty),
        .rcount   (rcount),
        .rerr     (rerr)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // Advance one rising edge and land 1 time unit after it.
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic read_n(input int n);
        rinc = 1'b1;
        repeat (n) tick();
        rinc = 1'b0;
    endtask

    task automatic test_power_on();
        total++; if (rempty !== 1'b1) $display("FAIL po_rempty: got %b expected 1", rempty); else passed++;
        total++; if (raempty !== 1'b1) $display("FAIL po_raempty: got %b expected 1", raempty); else passed++;
        total++; if (rptr !== 5'd0) $display("FAIL po_rptr: got %b expected 00000", rptr); else passed++;
        total++; if (rcount !== 5'd0) $display("FAIL po_rcount: got %0d expected 0", rcount); else passed++;
        total++; if (rerr !== 1'b0) $display("FAIL po_rerr: got %b expected 0", rerr); else passed++;
    endtask

    task automatic test_single_write();
        wptr = 5'b00001;
        tick();
        total++; if (rq2_wptr !== 5'b00000) $display("FAIL sw_rq2_e1: got %b expected 00000", rq2_wptr); else passed++;
        tick();
        total++; if (rq2_wptr !== 5'b00001) $display("FAIL sw_rq2_e2: got %b expected 00001", rq2_wptr); else passed++;
        total++; if (rempty !== 1'b1) $display("FAIL sw_rempty_e2: got %b expected 1", rempty); else passed++;
        tick();
        total++; if (rempty !== 1'b0) $display("FAIL sw_rempty_e3: got %b expected 0", rempty); else passed++;
        total++; if (rcount !== 5'd1) $display("FAIL sw_rcount_e3: got %0d expected 1", rcount); else passed++;
        total++; if (raempty !== 1'b1) $display("FAIL sw_raempty_e3: got %b expected 1", raempty); else passed++;
    endtask

    task automatic test_drain();
        wptr = 5'b00111;
        repeat (3) tick();
        total++; if (rcount !== 5'd5) $display("FAIL dr_rcount_init: got %0d expected 5", rcount); else passed++;
        total++; if (raempty !== 1'b0) $display("FAIL dr_raempty_init: got %b expected 0", raempty); else passed++;
        rinc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++; if (raddr !== 4'(i)) $display("FAIL dr_raddr[%0d]: got %0d expected %0d", i, raddr, i); else passed++;
            tick();
            total++; if (rcount !== 5'(4 - i)) $display("FAIL dr_rcount[%0d]: got %0d expected %0d", i, rcount, 4 - i); else passed++;
            total++; if (raempty !== ((4 - i) <= 2)) $display("FAIL dr_raempty[%0d]: got %b expected %b", i, raempty, ((4 - i) <= 2)); else passed++;
        end
        rinc = 1'b0;
        total++; if (rempty !== 1'b1) $display("FAIL dr_rempty: got %b expected 1", rempty); else passed++;
        total++; if (rptr !== 5'b00111) $display("FAIL dr_rptr: got %b expected 00111", rptr); else passed++;
    endtask

    task automatic test_underflow();
        rinc = 1'b1;
        tick();
        total++; if (raddr !== 4'd5) $display("FAIL uf_raddr: got %0d expected 5", raddr); else passed++;
        total++; if (rptr !== 5'b00111) $display("FAIL uf_rptr: got %b expected 00111", rptr); else passed++;
        total++; if (rerr !== 1'b1) $display("FAIL uf_rerr: got %b expected 1", rerr); else passed++;
        total++; if (rempty !== 1'b1) $display("FAIL uf_rempty: got %b expected 1", rempty); else passed++;
        rinc = 1'b0;
        repeat (2) tick();
        total++; if (rerr !== 1'b1) $display("FAIL uf_rerr_sticky: got %b expected 1", rerr); else passed++;
        total++; if (raddr !== 4'd5) $display("FAIL uf_raddr_hold: got %0d expected 5", raddr); else passed++;
    endtask

    task automatic test_reset();
        // Mid-cycle asynchronous pulse while rptr, raddr and rerr are nonzero.
        rrst = 1'b1;
        #1;
        total++; if (rempty !== 1'b1) $display("FAIL rs_rempty: got %b expected 1", rempty); else passed++;
        total++; if (raempty !== 1'b1) $display("FAIL rs_raempty: got %b expected 1", raempty); else passed++;
        total++; if (rptr !== 5'd0) $display("FAIL rs_rptr: got %b expected 00000", rptr); else passed++;
        total++; if (raddr !== 4'd0) $display("FAIL rs_raddr: got %0d expected 0", raddr); else passed++;
        total++; if (rcount !== 5'd0) $display("FAIL rs_rcount: got %0d expected 0", rcount); else passed++;
        total++; if (rerr !== 1'b0) $display("FAIL rs_rerr: got %b expected 0", rerr); else passed++;
        total++; if (rq2_wptr !== 5'd0) $display("FAIL rs_rq2: got %b expected 00000", rq2_wptr); else passed++;
        #1;
        rrst = 1'b0;
    endtask

    task automatic test_wrap();
        // Walk rbin up to 30 in two batches of 15 reads.
        wptr = gray(5'd15);
        repeat (3) tick();
        read_n(15);
        total++; if (rempty !== 1'b1) $display("FAIL wr_rempty_15: got %b expected 1", rempty); else passed++;
        wptr = gray(5'd30);
        repeat (3) tick();
        read_n(15);
        total++; if (raddr !== 4'd14) $display("FAIL wr_raddr_30: got %0d expected 14", raddr); else passed++;
        wptr = 5'b00010;
        repeat (3) tick();
        total++; if (rcount !== 5'd5) $display("FAIL wr_rcount_pre: got %0d expected 5", rcount); else passed++;
        rinc = 1'b1;
        tick();
        total++; if (rptr !== 5'b10000) $display("FAIL wr_rptr_31: got %b expected 10000", rptr); else passed++;
        total++; if (rcount !== 5'd4) $display("FAIL wr_rcount_31: got %0d expected 4", rcount); else passed++;
        tick();
        rinc = 1'b0;
        total++; if (raddr !== 4'd0) $display("FAIL wr_raddr_0: got %0d expected 0", raddr); else passed++;
        total++; if (rptr !== 5'b00000) $display("FAIL wr_rptr_0: got %b expected 00000", rptr); else passed++;
        total++; if (rcount !== 5'd3) $display("FAIL wr_rcount_0: got %0d expected 3", rcount); else passed++;
        total++; if (rempty !== 1'b0) $display("FAIL wr_rempty_0: got %b expected 0", rempty); else passed++;
    endtask

    task automatic test_reset_midstream();
        // State: rcount=3, rbin=0, wptr=gray(3). A read is pending.
        rinc = 1'b1;
        #2;
        rrst = 1'b1;
        rinc = 1'b0;
        #1;
        total++; if (rcount !== 5'd0) $display("FAIL rm_rcount: got %0d expected 0", rcount); else passed++;
        total++; if (rempty !== 1'b1) $display("FAIL rm_rempty: got %b expected 1", rempty); else passed++;
        total++; if (raempty !== 1'b1) $display("FAIL rm_raempty: got %b expected 1", raempty); else passed++;
        total++; if (rq2_wptr !== 5'd0) $display("FAIL rm_rq2: got %b expected 00000", rq2_wptr); else passed++;
        total++; if (raddr !== 4'd0) $display("FAIL rm_raddr: got %0d expected 0", raddr); else passed++;
        #1;
        rrst = 1'b0;
        tick();
        total++; if (rcount !== 5'd0) $display("FAIL rm_rcount_e1: got %0d expected 0", rcount); else passed++;
        tick();
        total++; if (rcount !== 5'd0) $display("FAIL rm_rcount_e2: got %0d expected 0", rcount); else passed++;
        total++; if (rempty !== 1'b1) $display("FAIL rm_rempty_e2: got %b expected 1", rempty); else passed++;
        tick();
        total++; if (rcount !== 5'd3) $display("FAIL rm_rcount_e3: got %0d expected 3", rcount); else passed++;
        total++; if (rempty !== 1'b0) $display("FAIL rm_rempty_e3: got %b expected 0", rempty); else passed++;
        total++; if (rerr !== 1'b0) $display("FAIL rm_rerr: got %b expected 0", rerr); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rrst   = 1'b1;
        rinc   = 1'b0;
        wptr   = 5'd0;
        #1;
        test_power_on();
        repeat (2) tick();
        rrst = 1'b0;

        test_single_write();
        test_drain();
        test_underflow();
        test_reset();
        test_wrap();
        test_reset_midstream();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rptr_empty_w2r.md
RPTR_EMPTY_W2R -- requirements
Module: rptr_empty_w2r

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4: FIFO address width; pointers are ADDRSIZE+1 bits.
REQ-002 SHALL have parameter AEMPTY_THRESH, default 2: almost-empty threshold, in entries.
REQ-003 SHALL have port rclk, input, 1 bit: read clock; the only clock.
REQ-004 SHALL have port rrst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port rinc, input, 1 bit: read request, sampled on the rclk rising edge.
REQ-006 SHALL have port wptr, input, ADDRSIZE+1 bits: Gray-coded write pointer from the wclk domain, asynchronous to rclk.
REQ-007 SHALL have port raddr, output, ADDRSIZE bits: binary read address to the FIFO memory.
REQ-008 SHALL have port rptr, output, ADDRSIZE+1 bits: registered Gray-coded read pointer, sent to the write domain.
REQ-009 SHALL have port rq2_wptr, output, ADDRSIZE+1 bits: write pointer after synchronization into rclk.
REQ-010 SHALL have port rempty, output, 1 bit: registered FIFO-empty flag.
REQ-011 SHALL have port raempty, output, 1 bit: registered almost-empty flag.
REQ-012 SHALL have port rcount, output, ADDRSIZE+1 bits: registered occupancy as seen from the read side.
REQ-013 SHALL have port rerr, output, 1 bit: sticky underflow flag.

Function
REQ-014 SHALL synchronize wptr through two flops clocked by rclk: rq1_wptr <= wptr, then rq2_wptr <= rq1_wptr; no logic between the stages.
REQ-015 SHALL hold a binary read pointer rbin of ADDRSIZE+1 bits, with rbinnext = rbin + (rinc AND NOT rempty), computed modulo 2^(ADDRSIZE+1).
REQ-016 SHALL compute rgraynext = (rbinnext >> 1) XOR rbinnext, and register rbin <= rbinnext and rptr <= rgraynext on every rclk edge.
REQ-017 SHALL drive raddr = rbin[ADDRSIZE-1:0] combinationally from the register, so the read data address is valid the same cycle rinc is presented.
REQ-018 SHALL register rempty <= (rgraynext == rq2_wptr).
REQ-019 SHALL convert rq2_wptr from Gray to binary (rq2_wbin) by prefix XOR from the MSB down.
REQ-020 SHALL register rcount <= (rq2_wbin - rbinnext) modulo 2^(ADDRSIZE+1), and register raempty <= (that same next value <= AEMPTY_THRESH).
REQ-021 SHALL ignore rinc while rempty=1: pointers stay unchanged and rerr <= 1; rerr clears only on reset.
REQ-022 SHALL wrap pointers naturally: rbin goes 2^(ADDRSIZE+1)-1 -> 0, the rptr MSB toggles, and raddr goes 2^ADDRSIZE-1 -> 0; rcount SHALL stay correct across the wrap.
REQ-023 SHALL meet this latency: a wptr change is visible on rq2_wptr after 2 rclk edges, and rempty/rcount/raempty update on the 3rd edge.
REQ-024 SHALL handle a simultaneous read and incoming write pointer update by computing the flags from rbinnext and the current rq2_wptr; the flags are pessimistic, never optimistic.
REQ-025 SHALL assume the writer never overfills, so rcount <= 2^ADDRSIZE; behaviour beyond that is undefined and is not flagged.

Reset
REQ-026 SHALL, on rrst=1, immediately and without a clock clear rq1_wptr, rq2_wptr, rbin, rptr, rcount and rerr to 0, and set rempty=1 and raempty=1.
REQ-027 SHALL, on reset asserted mid-operation, abandon any pending read; the first rclk edge after rrst deasserts SHALL behave as post-reset operation.

Verification (ADDRSIZE=4, AEMPTY_THRESH=2)
REQ-028 SHALL cover reset: pulse rrst while outputs are nonzero -> same timestep rempty=1, raempty=1, rptr=0, raddr=0, rcount=0, rerr=0.
REQ-029 SHALL cover single-write latency: wptr=00001 applied before edge 1 -> rq2_wptr=00001 after edge 2; rempty=0, rcount=1, raempty=1 after edge 3.
REQ-030 SHALL cover a drain: wptr=gray(5)=00111, synced, then rinc held 5 cycles -> raddr 0,1,2,3,4; rcount 4,3,2,1,0; raempty=0 at rcount 4 and 3; rempty=1 after the 5th read; rptr=00111.
REQ-031 SHALL cover underflow: rinc=1 while rempty=1 -> rbin, rptr and raddr unchanged; rerr=1 and it stays 1 after rinc drops.
REQ-032 SHALL cover wrap: rbin=30 and wptr=gray(3)=00010 synced -> rcount=5; after 2 reads rbin=0, rptr=00000, raddr=0, rcount=3.
REQ-033 SHALL cover reset mid-stream: rcount=3, rinc=1, assert rrst between edges -> all outputs at reset values immediately, and rcount stays 0 until wptr resynchronizes.
